// File: rtl/mqst_pkg.sv
// Shared types and timing helpers for the Manchester byte link (transmitter and receiver).
package mqst_pkg;

  typedef enum logic {IDLE, RUN} state_t;

  localparam int HALF_BIT_DEF = 8;
  localparam bit MSB_FIRST    = 1'b1;

  // Edges closer than WIN_LO to the last mid-bit edge are bit boundaries; WIN_TO ends a frame.
  function automatic int win_lo(input int half_bit);
    return 3 * half_bit / 2;
  endfunction

  function automatic int win_to(input int half_bit);
    return 5 * half_bit / 2;
  endfunction

  localparam int WIN_LO = 3 * HALF_BIT_DEF / 2;
  localparam int WIN_TO = 5 * HALF_BIT_DEF / 2;

  function automatic logic [7:0] shift_in(input logic [7:0] sh, input logic b);
    if (MSB_FIRST)
      return {sh[6:0], b};
    else
      return {b, sh[7:1]};
  endfunction

endpackage

// File: rtl/mqst_edge_sync.sv
// Two-flop synchronizer for the raw line plus registered level/edge/rise detection.
module mqst_edge_sync (
  input  logic clk,
  input  logic rst_p,
  input  logic din,
  output logic level,
  output logic edge_hit,
  output logic rise
);

  logic sync1;
  logic sync2;
  logic prev;

  // Outputs are registered so level, edge_hit and rise always describe the same sample.
  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      prev     <= 1'b0;
      level    <= 1'b0;
      edge_hit <= 1'b0;
      rise     <= 1'b0;
    end else begin
      sync1    <= din;
      sync2    <= sync1;
      prev     <= sync2;
      level    <= sync2;
      edge_hit <= sync2 ^ prev;
      rise     <= sync2 & ~prev;
    end
  end

endmodule

// File: rtl/mqst_byte_rx.sv
// Manchester byte receiver: recovers bit timing from mid-bit edges and assembles bytes MSB first.
module mqst_byte_rx
  import mqst_pkg::*;
#(
  parameter int HALF_BIT = 8,
  parameter int CNT_W    = 10
) (
  input  logic       clk,
  input  logic       rst_p,
  input  logic       Mqst_BitIn,
  output logic [7:0] data_out,
  output logic       data_out_valid,
  output logic       frame_active,
  output logic       frame_err,
  output logic       code_err
);

  localparam logic [CNT_W-1:0] LO  = CNT_W'(win_lo(HALF_BIT));
  localparam logic [CNT_W-1:0] TO  = CNT_W'(win_to(HALF_BIT));
  localparam logic [CNT_W-1:0] MAX = '1;

  logic level;
  logic edge_hit;
  logic rise;

  mqst_edge_sync u_sync (
    .clk      (clk),
    .rst_p    (rst_p),
    .din      (Mqst_BitIn),
    .level    (level),
    .edge_hit (edge_hit),
    .rise     (rise)
  );

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic [2:0]       bit_cnt, bit_cnt_n;
  logic [7:0]       shreg, shreg_n;
  logic             seen, seen_n;
  logic [7:0]       data_n;
  logic             valid_n, ferr_n, cerr_n;

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      state          <= IDLE;
      cnt            <= '0;
      bit_cnt        <= '0;
      shreg          <= '0;
      seen           <= 1'b0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      frame_err      <= 1'b0;
      code_err       <= 1'b0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      bit_cnt        <= bit_cnt_n;
      shreg          <= shreg_n;
      seen           <= seen_n;
      data_out       <= data_n;
      data_out_valid <= valid_n;
      frame_err      <= ferr_n;
      code_err       <= cerr_n;
    end
  end

  assign cnt_inc      = (cnt == MAX) ? cnt : cnt + 1'b1;
  assign frame_active = (state == RUN);

  // An edge arriving in the same cycle as the timeout is still decoded.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    seen_n    = seen;
    data_n    = data_out;
    valid_n   = 1'b0;
    ferr_n    = 1'b0;
    cerr_n    = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_n   = RUN;
          cnt_n     = '0;
          bit_cnt_n = '0;
          seen_n    = 1'b0;
        end
      end
      RUN: begin
        if (edge_hit) begin
          if (cnt < LO) begin
            if (seen) begin
              cerr_n  = 1'b1;
              state_n = IDLE;
            end else begin
              seen_n = 1'b1;
              cnt_n  = cnt_inc;
            end
          end else begin
            shreg_n = shift_in(shreg, level);
            cnt_n   = '0;
            seen_n  = 1'b0;
            if (bit_cnt == 3'd7) begin
              data_n    = shreg_n;
              valid_n   = 1'b1;
              bit_cnt_n = 3'd0;
            end else begin
              bit_cnt_n = bit_cnt + 3'd1;
            end
          end
        end else if (cnt == TO) begin
          state_n = IDLE;
          ferr_n  = (bit_cnt != 3'd0);
        end else begin
          cnt_n = cnt_inc;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
